// File: rtl/uart_pkg.sv
// Shared definitions for the UART image loader: FSM encoding, word geometry
// and the big-endian byte packer.
package uart_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_t;

  // Byte 0 starts a fresh word, so the unfilled low bytes come out as zero.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w = {word[31:24], b, word[15:0]};
      2'd2:    w = {word[31:16], b, word[7:0]};
      default: w = {word[31:8], b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Received-byte stream: one data byte qualified by a single-cycle valid.
interface uart_loader_if;

  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);

endinterface

// File: rtl/uart_loader_skid.sv
// One-entry skid buffer that parks a byte arriving while a memory write is pending.
module uart_loader_skid (
  input  logic         i_clk_uart,
  input  logic         i_rst_n,
  uart_loader_if.slave wr,
  input  logic         pop,
  output logic         full,
  output logic [7:0]   data
);

  logic       full_reg;
  logic [7:0] data_reg;

  // The owner only pushes when empty or when popping in the same cycle.
  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_reg <= 1'b0;
      data_reg <= 8'h00;
    end else if (wr.valid) begin
      full_reg <= 1'b1;
      data_reg <= wr.data;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign data = data_reg;

endmodule

// File: rtl/uart_loader.sv
// Packs received UART bytes into 32-bit big-endian words and writes them to memory.
// Define UART_LOADER_CHECKSUM_EN to build the per-image modulo-256 byte checksum.
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk_uart,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  input  logic                  i_clear_sign,
  input  logic                  i_mem_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overflow,
  output logic [7:0]            o_checksum
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]      IDX_ONE   = 1;
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = MAX_WORDS - CNT_ONE;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t         state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  flush_reg, flush_next;

  logic       skid_push, skid_pop, skid_full;
  logic [7:0] skid_data;
  logic       take, start;
  logic [7:0] take_byte;

  uart_loader_if skid_wr ();
  assign skid_wr.data  = i_data;
  assign skid_wr.valid = skid_push;

  uart_loader_skid u_skid (
    .i_clk_uart (i_clk_uart),
    .i_rst_n    (i_rst_n),
    .wr         (skid_wr),
    .pop        (skid_pop),
    .full       (skid_full),
    .data       (skid_data)
  );

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wdata_reg    <= 32'h0;
      addr_reg     <= BASE;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      flush_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      wdata_reg    <= wdata_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      flush_reg    <= flush_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    wdata_next    = wdata_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    flush_next    = flush_reg;
    skid_push     = 1'b0;
    skid_pop      = 1'b0;
    take          = 1'b0;
    start         = 1'b0;
    take_byte     = 8'h00;

    case (state_reg)
      IDLE, DONE, COLLECT: begin
        // A parked byte is always older than one arriving now, so it goes first
        // and the new byte refills the buffer in the same cycle.
        if (skid_full) begin
          take      = 1'b1;
          take_byte = skid_data;
          skid_pop  = 1'b1;
          skid_push = i_valid;
        end else if (i_valid) begin
          take      = 1'b1;
          take_byte = i_data;
        end else if (state_reg == COLLECT && i_clear_sign) begin
          if (idx_reg == '0) begin
            state_next = DONE;
          end else if (count_reg == MAX_WORDS) begin
            overflow_next = 1'b1;
            idx_next      = '0;
            state_next    = DONE;
          end else begin
            flush_next = 1'b1;
            state_next = WRITE;
          end
        end
        start = take && (state_reg != COLLECT);
      end
      WRITE: begin
        if (i_valid) begin
          if (skid_full) overflow_next = 1'b1;
          else           skid_push     = 1'b1;
        end
        if (i_mem_ready) begin
          count_next = count_reg + CNT_ONE;
          // Hold the last address once memory is full instead of wrapping.
          if (count_reg != LAST_CNT) addr_next = addr_reg + ADDR_ONE;
          idx_next   = '0;
          flush_next = 1'b0;
          state_next = flush_reg ? DONE : COLLECT;
        end
      end
      default: state_next = IDLE;
    endcase

    if (start) begin
      addr_next     = BASE;
      count_next    = '0;
      overflow_next = 1'b0;
      flush_next    = 1'b0;
      wdata_next    = pack_byte(wdata_reg, 2'd0, take_byte);
      idx_next      = IDX_ONE;
      state_next    = COLLECT;
    end else if (take) begin
      wdata_next = pack_byte(wdata_reg, idx_reg, take_byte);
      if (idx_reg == IDX_LAST) begin
        idx_next = '0;
        if (count_reg == MAX_WORDS) overflow_next = 1'b1;
        else                        state_next    = WRITE;
      end else begin
        idx_next = idx_reg + IDX_ONE;
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg, checksum_next;

  always_comb begin
    checksum_next = checksum_reg;
    if (start)     checksum_next = take_byte;
    else if (take) checksum_next = checksum_reg + take_byte;
  end

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) checksum_reg <= 8'h00;
    else          checksum_reg <= checksum_next;
  end

  assign o_checksum = checksum_reg;
`else
  assign o_checksum = 8'h00;
`endif

  assign o_mem_we     = (state_reg == WRITE);
  assign o_mem_addr   = addr_reg;
  assign o_mem_wdata  = wdata_reg;
  assign o_busy       = (state_reg == COLLECT) || (state_reg == WRITE);
  assign o_done       = (state_reg == DONE);
  assign o_word_count = count_reg;
  assign o_overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: default-size instance plus a 4-word instance
// for the memory-full case. Checksum expectation follows UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_sign = 1'b0;
  logic mem_ready = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if rx_bus ();

  logic        mem_we, busy, done, overflow;
  logic [7:0]  mem_addr, checksum;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        s_mem_we, s_busy, s_done, s_overflow;
  logic [1:0]  s_mem_addr;
  logic [7:0]  s_checksum;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_word_count;

  uart_loader dut (
    .i_clk_uart   (clk),
    .i_rst_n      (rst_n),
    .i_data       (rx_bus.data),
    .i_valid      (rx_bus.valid),
    .i_clear_sign (clear_sign),
    .i_mem_ready  (mem_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_word_count (word_count),
    .o_overflow   (overflow),
    .o_checksum   (checksum)
  );

  uart_loader #(.ADDR_WIDTH(2)) dut_small (
    .i_clk_uart   (clk),
    .i_rst_n      (rst_n),
    .i_data       (rx_bus.data),
    .i_valid      (rx_bus.valid),
    .i_clear_sign (clear_sign),
    .i_mem_ready  (mem_ready),
    .o_mem_we     (s_mem_we),
    .o_mem_addr   (s_mem_addr),
    .o_mem_wdata  (s_mem_wdata),
    .o_busy       (s_busy),
    .o_done       (s_done),
    .o_word_count (s_word_count),
    .o_overflow   (s_overflow),
    .o_checksum   (s_checksum)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int small_writes = 0;

  // Record every accepted write (inputs change 1 time unit after the edge).
  always @(posedge clk) begin
    if (mem_we && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      $display("write addr=0x%02h data=0x%08h", mem_addr, mem_wdata);
    end
    if (s_mem_we && mem_ready) small_writes++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_bus.data  = b;
    rx_bus.valid = 1'b1;
    tick(1);
    rx_bus.valid = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic expect_write(input string tag, input int idx,
                              input logic [7:0] a, input logic [31:0] d);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, wr_addr_q[idx], a);
      check({tag, "_data"}, wr_data_q[idx], d);
    end else begin
      check({tag, "_present"}, wr_addr_q.size(), idx + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    mem_we,     1'b0);
    check({tag, "_addr"},  mem_addr,   8'h00);
    check({tag, "_wdata"}, mem_wdata,  32'h0);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_done"},  done,       1'b0);
    check({tag, "_count"}, word_count, 9'd0);
    check({tag, "_ovf"},   overflow,   1'b0);
    check({tag, "_csum"},  checksum,   8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] exp_csum;
    rx_bus.data  = 8'h00;
    rx_bus.valid = 1'b0;

    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);

    // One full word with memory always ready.
    base = wr_addr_q.size();
    mem_ready = 1'b1;
    send_byte(8'h12, 3);
    send_byte(8'h34, 3);
    send_byte(8'h56, 3);
    send_byte(8'h78, 4);
    check("w1_nwrites", wr_addr_q.size() - base, 1);
    expect_write("w1", base, 8'h00, 32'h12345678);
    check("w1_count", word_count, 9'd1);
    check("w1_busy", busy, 1'b1);
    clear_sign = 1'b1;
    tick(2);
    clear_sign = 1'b0;
    tick(1);
    check("w1_done", done, 1'b1);
    check("w1_busy_end", busy, 1'b0);

    // Two words then line idle.
    do_reset();
    base = wr_addr_q.size();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 3);
    tick(2);
    clear_sign = 1'b1;
    tick(2);
    clear_sign = 1'b0;
    tick(1);
    check("w2_nwrites", wr_addr_q.size() - base, 2);
    expect_write("w2_first", base, 8'h00, 32'h01020304);
    expect_write("w2_second", base + 1, 8'h01, 32'h05060708);
    check("w2_done", done, 1'b1);
    check("w2_busy", busy, 1'b0);
    check("w2_count", word_count, 9'd2);

    // Partial word from DONE: restart, zero-pad, flush.
    base = wr_addr_q.size();
    send_byte(8'hAA, 3);
    check("pad_restart_done", done, 1'b0);
    send_byte(8'hBB, 3);
    clear_sign = 1'b1;
    tick(4);
    clear_sign = 1'b0;
    tick(1);
    check("pad_nwrites", wr_addr_q.size() - base, 1);
    expect_write("pad", base, 8'h00, 32'hAABB0000);
    check("pad_done", done, 1'b1);
    check("pad_count", word_count, 9'd1);

    // Memory stalled: hold the write, skid one byte, drop the next.
    do_reset();
    base = wr_addr_q.size();
    mem_ready = 1'b0;
    send_byte(8'hC1, 2);
    send_byte(8'hC2, 2);
    send_byte(8'hC3, 2);
    send_byte(8'hC4, 0);
    check("stall_we_rise", mem_we, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 8) begin
        rx_bus.data  = (i == 3) ? 8'hD1 : 8'hD2;
        rx_bus.valid = 1'b1;
      end
      tick(1);
      rx_bus.valid = 1'b0;
      check("stall_we", mem_we, 1'b1);
      check("stall_data", mem_wdata, 32'hC1C2C3C4);
      check("stall_addr", mem_addr, 8'h00);
    end
    check("stall_ovf", overflow, 1'b1);
    mem_ready = 1'b1;
    tick(1);
    send_byte(8'hE2, 2);
    send_byte(8'hE3, 2);
    send_byte(8'hE4, 4);
    check("stall_nwrites", wr_addr_q.size() - base, 2);
    expect_write("stall_first", base, 8'h00, 32'hC1C2C3C4);
    expect_write("stall_skid", base + 1, 8'h01, 32'hD1E2E3E4);
    check("stall_count", word_count, 9'd2);
    check("stall_ovf_sticky", overflow, 1'b1);

    // Four-word memory receives five words.
    do_reset();
    base = small_writes;
    for (int i = 0; i < 20; i++) send_byte(8'(i), 2);
    tick(4);
    check("full_nwrites", small_writes - base, 4);
    check("full_count", s_word_count, 3'd4);
    check("full_ovf", s_overflow, 1'b1);
    check("full_addr", s_mem_addr, 2'd3);
    check("full_big_count", word_count, 9'd5);

    // Checksum, then reset while a write is pending.
    do_reset();
    mem_ready = 1'b0;
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 0);
`ifdef UART_LOADER_CHECKSUM_EN
    exp_csum = 8'h01;
`else
    exp_csum = 8'h00;
`endif
    check("csum_value", checksum, exp_csum);
    check("csum_we", mem_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(1);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    base = wr_addr_q.size();
    tick(5);
    check("midrst_nowrite", wr_addr_q.size() - base, 0);
    check("midrst_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
